// File: rtl/knight_pkg.sv
// ---------------------------------------------------------------------------
// knight_pkg
// Shared definitions for the NEMO inertial-sensor configuration sequencer:
// the sequencer state encoding and the SPI command words written to the
// sensor. Command words are {R/W + addr[7:0], data[7:0]}.
// ---------------------------------------------------------------------------
package knight_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_CFG_INT,
        ST_CFG_GYRO,
        ST_CFG_RND,
        ST_IDLE,
        ST_RD_YL,
        ST_RD_YH
    } state_t;

    // Configuration writes, issued once after power-up
    localparam logic [15:0] CMD_INT_CFG  = 16'h0D02;  // data-ready interrupt enable
    localparam logic [15:0] CMD_GYRO_CFG = 16'h1160;  // gyro rate / range
    localparam logic [15:0] CMD_RND_CFG  = 16'h1440;  // rounding control

    // Yaw-rate reads (bit 15 set = read)
    localparam logic [15:0] CMD_RD_YAWL  = 16'hA600;
    localparam logic [15:0] CMD_RD_YAWH  = 16'hA700;

endpackage

// File: rtl/int_sync.sv
// ---------------------------------------------------------------------------
// int_sync
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Output follows the input with two cycles of latency.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset (both flops clear to 0)
//   async_in  asynchronous input level
//   sync_out  synchronized level
// ---------------------------------------------------------------------------
module int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // NOTE: non-blocking assignments make both flops sample their pre-edge
    // inputs; with blocking assignments the chain would collapse into one flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/inert_cfg_seq.sv
// ---------------------------------------------------------------------------
// inert_cfg_seq
// Drives an external SPI master to configure the NEMO inertial sensor after
// power-up, then reads the 16-bit signed yaw rate each time the sensor
// raises its data-ready interrupt.
//
// Parameters
//   PWR_WAIT   clk cycles to wait after reset release before the first write
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   INT        sensor data-ready interrupt (asynchronous)
//   done       SPI transaction-complete pulse
//   rd_data    SPI read data, valid while done=1
//   wrt        SPI start strobe (1-cycle pulse)
//   cmd        SPI command word, held from wrt until the next wrt
//   init_done  high once all configuration writes have completed
//   yaw_rt     signed yaw rate {yawH, yawL}
//   vld        1-cycle pulse in the cycle yaw_rt updates
// ---------------------------------------------------------------------------
module inert_cfg_seq
    import knight_pkg::*;
#(
    parameter logic [15:0] PWR_WAIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        init_done,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    state_t      state, state_nxt;
    logic [15:0] pwr_cnt, pwr_cnt_nxt;
    logic        busy, busy_nxt;          // a wrt has been issued, its done not yet seen
    logic [7:0]  yaw_l, yaw_l_nxt;
    logic        wrt_nxt;
    logic [15:0] cmd_nxt;
    logic        init_done_nxt;
    logic [15:0] yaw_rt_nxt;
    logic        vld_nxt;
    logic        int_s;
    logic        done_ok;

    // Only the low byte of each read carries register data
    logic        rd_hi_unused;
    assign rd_hi_unused = ^rd_data[15:8];

    int_sync u_int_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (INT),
        .sync_out (int_s)
    );

    // A done with nothing outstanding is stray and must not advance the FSM
    assign done_ok = done & busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PWR_WAIT;
            pwr_cnt   <= '0;
            busy      <= 1'b0;
            yaw_l     <= '0;
            wrt       <= 1'b0;
            cmd       <= '0;
            init_done <= 1'b0;
            yaw_rt    <= '0;
            vld       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pwr_cnt   <= pwr_cnt_nxt;
            busy      <= busy_nxt;
            yaw_l     <= yaw_l_nxt;
            wrt       <= wrt_nxt;
            cmd       <= cmd_nxt;
            init_done <= init_done_nxt;
            yaw_rt    <= yaw_rt_nxt;
            vld       <= vld_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt     = state;
        pwr_cnt_nxt   = pwr_cnt;
        busy_nxt      = busy & ~done;
        yaw_l_nxt     = yaw_l;
        wrt_nxt       = 1'b0;
        cmd_nxt       = cmd;
        init_done_nxt = init_done;
        yaw_rt_nxt    = yaw_rt;
        vld_nxt       = 1'b0;

        case (state)
            ST_PWR_WAIT: begin
                // Compare before incrementing: the counter stops at PWR_WAIT
                // and can never wrap, even for PWR_WAIT = 16'hFFFF.
                if (pwr_cnt == PWR_WAIT) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_INT_CFG;
                    state_nxt = ST_CFG_INT;
                end else begin
                    pwr_cnt_nxt = pwr_cnt + 16'd1;
                end
            end
            ST_CFG_INT: begin
                if (done_ok) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_GYRO_CFG;
                    state_nxt = ST_CFG_GYRO;
                end
            end
            ST_CFG_GYRO: begin
                if (done_ok) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_RND_CFG;
                    state_nxt = ST_CFG_RND;
                end
            end
            ST_CFG_RND: begin
                if (done_ok) begin
                    init_done_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (int_s && !busy) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_RD_YAWL;
                    state_nxt = ST_RD_YL;
                end
            end
            ST_RD_YL: begin
                if (done_ok) begin
                    yaw_l_nxt = rd_data[7:0];
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_RD_YAWH;
                    state_nxt = ST_RD_YH;
                end
            end
            ST_RD_YH: begin
                if (done_ok) begin
                    yaw_rt_nxt = {rd_data[7:0], yaw_l};
                    vld_nxt    = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_PWR_WAIT;
        endcase

        if (wrt_nxt) begin
            busy_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_inert_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_inert_cfg_seq
// Directed bench for inert_cfg_seq with PWR_WAIT=16 and an SPI master model
// that returns done 32 cycles after each wrt.
// ---------------------------------------------------------------------------
module tb_inert_cfg_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;
    logic        done;
    logic [15:0] rd_data = '0;
    logic        wrt;
    logic [15:0] cmd;
    logic        init_done;
    logic [15:0] yaw_rt;
    logic        vld;

    int n_eval = 0;
    int n_fail = 0;

    // SPI model bookkeeping
    int          wrt_cnt = 0;
    int          vld_cnt = 0;
    int          overlap_cnt = 0;
    logic        pend = 1'b0;
    int          pend_cyc = 0;
    logic [15:0] pend_cmd = '0;
    logic [15:0] yl_val = '0;
    logic [15:0] yh_val = '0;

    assign done = model_done | spur_done;

    inert_cfg_seq #(.PWR_WAIT(16'd16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .INT       (INT),
        .done      (done),
        .rd_data   (rd_data),
        .wrt       (wrt),
        .cmd       (cmd),
        .init_done (init_done),
        .yaw_rt    (yaw_rt),
        .vld       (vld)
    );

    always #5 clk = ~clk;

    // SPI master model: done 32 cycles after wrt, read data chosen by command
    always @(negedge clk) begin
        model_done = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend_cyc--;
                if (pend_cyc == 0) begin
                    model_done = 1'b1;
                    rd_data    = (pend_cmd == 16'hA600) ? yl_val : yh_val;
                    pend       = 1'b0;
                end
            end
            if (wrt) begin
                wrt_cnt++;
                if (pend) overlap_cnt++;
                pend     = 1'b1;
                pend_cyc = 32;
                pend_cmd = cmd;
            end
            if (vld) vld_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_wrt(input string tag, output logic [15:0] c);
        bit seen = 1'b0;
        int i = 0;
        c = '0;
        while (!seen && i < 200) begin
            tick();
            i++;
            if (wrt === 1'b1) begin
                seen = 1'b1;
                c    = cmd;
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        int i = 0;
        while (!seen && i < 200) begin
            tick();
            i++;
            if (model_done === 1'b1) seen = 1'b1;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_vld(input string tag);
        bit seen = 1'b0;
        int i = 0;
        while (!seen && i < 200) begin
            tick();
            i++;
            if (vld === 1'b1) seen = 1'b1;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Count cycles from reset release to the first wrt
    task automatic first_wrt_latency(input string tag, output int n);
        bit seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (wrt === 1'b1) seen = 1'b1;
        end
        check(tag, n, 17);
        check({tag, "_cmd"}, cmd, 16'h0D02);
    endtask

    initial begin
        logic [15:0] c;
        int n;
        int w0;
        int v0;
        int s;

        // ---- Reset state ----
        repeat (3) tick();
        check("rst_wrt", wrt, 0);
        check("rst_cmd", cmd, 0);
        check("rst_init_done", init_done, 0);
        check("rst_yaw_rt", yaw_rt, 0);
        check("rst_vld", vld, 0);

        // ---- Power-up wait then configuration, reset during CFG_GYRO ----
        rst_n = 1'b1;
        first_wrt_latency("first_wrt_lat", n);
        wait_wrt("cfg_gyro", c);
        check("cmd_gyro", c, 16'h1160);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_wrt", wrt, 0);
        check("midrst_cmd", cmd, 0);
        check("midrst_init_done", init_done, 0);
        check("midrst_yaw_rt", yaw_rt, 0);
        check("midrst_vld", vld, 0);
        repeat (3) tick();
        rst_n = 1'b1;

        first_wrt_latency("restart_wrt_lat", n);
        wait_wrt("cfg_gyro2", c);
        check("cmd_gyro2", c, 16'h1160);
        wait_wrt("cfg_rnd", c);
        check("cmd_rnd", c, 16'h1440);
        wait_done("cfg_rnd_done");
        check("init_before_done", init_done, 0);
        tick();
        check("init_done_rise", init_done, 1);
        check("overlap_cfg", overlap_cnt, 0);

        // ---- Single yaw read ----
        yl_val = 16'h0034;
        yh_val = 16'h0012;
        w0 = wrt_cnt;
        v0 = vld_cnt;
        INT = 1'b1;
        tick();
        INT = 1'b0;
        wait_wrt("rd_yl", c);
        check("cmd_rd_yl", c, 16'hA600);
        wait_wrt("rd_yh", c);
        check("cmd_rd_yh", c, 16'hA700);
        wait_done("rd_yh_done");
        check("vld_at_done", vld, 0);
        tick();
        check("vld_latency", vld, 1);
        check("yaw_1234", yaw_rt, 16'h1234);
        tick();
        check("vld_one_cycle", vld, 0);
        repeat (60) tick();
        check("single_wrt_cnt", wrt_cnt - w0, 2);
        check("single_vld_cnt", vld_cnt - v0, 1);

        // ---- INT pulses during RD_YL are ignored ----
        yl_val = 16'h0078;
        yh_val = 16'h0056;
        w0 = wrt_cnt;
        v0 = vld_cnt;
        INT = 1'b1;
        tick();
        INT = 1'b0;
        wait_wrt("ign_rd_yl", c);
        check("ign_cmd_yl", c, 16'hA600);
        repeat (3) begin
            repeat (3) tick();
            INT = 1'b1;
            tick();
            INT = 1'b0;
        end
        repeat (120) tick();
        check("ign_wrt_cnt", wrt_cnt - w0, 2);
        check("ign_vld_cnt", vld_cnt - v0, 1);
        check("ign_yaw", yaw_rt, 16'h5678);

        // ---- INT held high: back-to-back reads, negative yaw ----
        yl_val = 16'h0080;
        yh_val = 16'h00FF;
        w0 = wrt_cnt;
        v0 = vld_cnt;
        INT = 1'b1;
        wait_vld("b2b_vld1");
        check("yaw_ff80", yaw_rt, 16'hFF80);
        s = $signed(yaw_rt);
        check("yaw_signed", s, -128);
        tick();
        check("b2b_restart_wrt", wrt, 1);
        check("b2b_restart_cmd", cmd, 16'hA600);
        wait_vld("b2b_vld2");
        wait_vld("b2b_vld3");
        // Synchronizer still holds 1 for this IDLE cycle, so one more pair follows
        INT = 1'b0;
        repeat (100) tick();
        check("b2b_vld_cnt", vld_cnt - v0, 4);
        check("b2b_wrt_cnt", wrt_cnt - w0, 8);
        check("overlap_all", overlap_cnt, 0);

        // ---- Spurious done in IDLE ----
        w0 = wrt_cnt;
        v0 = vld_cnt;
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        repeat (20) tick();
        check("spur_wrt_cnt", wrt_cnt - w0, 0);
        check("spur_vld_cnt", vld_cnt - v0, 0);
        check("spur_cmd", cmd, 16'hA700);
        check("spur_yaw", yaw_rt, 16'hFF80);
        check("spur_init_done", init_done, 1);

        // Still in IDLE: a fresh interrupt starts a normal read
        yl_val = 16'h0034;
        yh_val = 16'h0012;
        INT = 1'b1;
        tick();
        INT = 1'b0;
        wait_wrt("post_spur_yl", c);
        check("post_spur_cmd", c, 16'hA600);
        wait_vld("post_spur_vld");
        check("post_spur_yaw", yaw_rt, 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule

// File: doc/inert_cfg_seq.md
INERT_CFG_SEQ -- requirements
Module: inert_cfg_seq

Interface
REQ-001 Parameter PWR_WAIT, default 16'hFFFF: number of clk cycles to wait after reset release before the first NEMO write.
REQ-002 clk  input  1  system clock; all logic is on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 INT  input  1  NEMO data-ready interrupt, asynchronous to clk.
REQ-005 done  input  1  SPI master transaction-complete pulse (1 cycle).
REQ-006 rd_data  input  16  SPI master read data, valid in the cycle done=1.
REQ-007 wrt  output  1  SPI master start strobe (1-cycle pulse).
REQ-008 cmd  output  16  SPI command word {R/W+addr[7:0], data[7:0]}; held stable from wrt until done.
REQ-009 init_done  output  1  high once all configuration writes have completed.
REQ-010 yaw_rt  output  16  signed yaw rate, {yawH, yawL}.
REQ-011 vld  output  1  1-cycle pulse in the cycle yaw_rt updates.

Function
REQ-012 States SHALL be PWR_WAIT, CFG_INT, CFG_GYRO, CFG_RND, IDLE, RD_YL, RD_YH.
REQ-013 PWR_WAIT: a 16-bit counter increments each cycle; when the count equals PWR_WAIT, assert wrt with cmd=16'h0D02 and go to CFG_INT.
REQ-014 CFG_INT: on done, assert wrt with cmd=16'h1160 and go to CFG_GYRO.
REQ-015 CFG_GYRO: on done, assert wrt with cmd=16'h1440 and go to CFG_RND.
REQ-016 CFG_RND: on done, set init_done and go to IDLE; init_done stays high until reset.
REQ-017 INT SHALL pass through a 2-flop synchronizer before use; latency is 2 cycles.
REQ-018 IDLE: when synchronized INT=1, assert wrt with cmd=16'hA600 and go to RD_YL.
REQ-019 RD_YL: on done, capture rd_data[7:0] into yawL, assert wrt with cmd=16'hA700, and go to RD_YH.
REQ-020 RD_YH: on done, load yaw_rt={rd_data[7:0], yawL}, pulse vld, and return to IDLE.
REQ-021 Latency from done in RD_YH to vld=1 SHALL be 1 cycle, with yaw_rt valid in the same cycle as vld.
REQ-022 INT is sampled only in IDLE; INT activity during RD_YL/RD_YH is ignored.
REQ-023 If INT is still high on return to IDLE, a new read starts on the next cycle.
REQ-024 wrt SHALL never assert while an SPI transaction is outstanding (between a wrt and its done).
REQ-025 A done arriving with no transaction outstanding SHALL be ignored and cause no state change.
REQ-026 cmd SHALL change only in the cycle wrt asserts.
REQ-027 The power-up counter SHALL NOT wrap before PWR_WAIT is reached.

Reset
REQ-028 While rst_n=0:
- state=PWR_WAIT, counter=0, wrt=0, cmd=0, init_done=0, yaw_rt=0, vld=0, yawL=0, synchronizer flops=0.
REQ-029 Reset mid-transaction SHALL abandon that transaction; after release the full configuration sequence restarts from PWR_WAIT.

Structure
REQ-030 The state enum and the NEMO command constants (16'h0D02, 16'h1160, 16'h1440, 16'hA600, 16'hA700) SHALL live in the shared knight_pkg package.
REQ-031 One sub-module, int_sync (2-flop synchronizer), SHALL be instantiated for INT.
REQ-032 The SPI master is external to this block.

Verification
REQ-033 Bench with PWR_WAIT=16, SPI model returning done 32 cycles after wrt; release reset:
- wrt pulses with cmds 0D02, 1160, 1440 in order;
- first wrt occurs 17 cycles after reset release;
- init_done rises 1 cycle after the third done.
REQ-034 After init, raise INT; model returns rd_data 16'h0034 then 16'h0012:
- cmds A600, A700 issued;
- vld pulses once with yaw_rt=16'h1234.
REQ-035 Pulse INT 3 times during RD_YL:
- exactly one read pair is issued;
- exactly one vld pulse.
REQ-036 Hold INT high continuously:
- back-to-back read pairs are issued;
- wrt is never asserted while a transaction is outstanding;
- yaw_rt=16'hFF80 reads as signed -128.
REQ-037 Assert rst_n=0 during CFG_GYRO:
- all outputs go to 0 immediately;
- after release, the sequence restarts with 0D02.
REQ-038 Inject a spurious done in IDLE:
- no state change;
- no wrt;
- no vld.
